// File: rtl/rgmii_inband_status_ctrl_if.sv
// Signal bundle between the RGMII/GMII bridge, the MAC TX observation points and the link-config controller.
// The controller takes the slave view; the bridge side (or a bench) drives through the master view.
interface rgmii_inband_status_ctrl_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [1:0] speed_selection;
  logic       duplex_mode;
  logic       link_up;
  logic       tx_hold;
  logic       cfg_update;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_tx_en, gmii_tx_er,
    input  speed_selection, duplex_mode, link_up, tx_hold, cfg_update
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_tx_en, gmii_tx_er,
    output speed_selection, duplex_mode, link_up, tx_hold, cfg_update
  );
endinterface

// File: rtl/rgmii_inband_status_ctrl.sv
// Debounces RGMII in-band status and applies speed/duplex/link only at a TX frame boundary.
// Latency STABLE_COUNT+2 cycles minimum; holds the MAC off (tx_hold) indefinitely while TX is busy.
module rgmii_inband_status_ctrl #(
  parameter int unsigned STABLE_COUNT   = 8,
  parameter logic [1:0]  DEFAULT_SPEED  = 2'b10,
  parameter logic        DEFAULT_DUPLEX = 1'b1
) (
  input logic                       gmii_rx_clk,
  input logic                       reset,
  rgmii_inband_status_ctrl_if.slave bus
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_COUNT);

  typedef enum logic [1:0] {MONITOR, PENDING, APPLY} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       cand_link, cand_duplex;
  logic [1:0] cand_speed;
  logic       link_q, duplex_q, hold_q, upd_q;
  logic [1:0] speed_q;

  logic       rx_idle, sample_ok, same_as_cand;
  logic       s_link, s_duplex;
  logic [1:0] s_speed;
  logic       accepted, change_pending, tx_idle, do_apply;

  assign rx_idle      = !bus.gmii_rx_dv && !bus.gmii_rx_er;
  assign s_link       = bus.gmii_rxd[0];
  assign s_speed      = bus.gmii_rxd[2:1];
  assign s_duplex     = bus.gmii_rxd[3];
  assign sample_ok    = (bus.gmii_rxd[7:4] == bus.gmii_rxd[3:0]) && (s_speed != 2'b11);
  assign same_as_cand = {s_link, s_speed, s_duplex} == {cand_link, cand_speed, cand_duplex};
  assign tx_idle      = !bus.gmii_tx_en && !bus.gmii_tx_er;

  // Status bits are only meaningful between frames; frame/error cycles freeze the debouncer.
  always_ff @(posedge gmii_rx_clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      cand_link   <= 1'b0;
      cand_speed  <= 2'b00;
      cand_duplex <= 1'b0;
    end else if (rx_idle) begin
      if (!sample_ok) begin
        cnt <= '0;
      end else if (same_as_cand) begin
        if (cnt < STABLE_CNT) cnt <= cnt + 8'd1;
      end else begin
        cand_link   <= s_link;
        cand_speed  <= s_speed;
        cand_duplex <= s_duplex;
        cnt         <= 8'd1;
      end
    end
  end

  assign accepted = (cnt == STABLE_CNT);

  // With link down the reported speed/duplex are meaningless, so only link_up is compared.
  assign change_pending = accepted &&
                          (cand_link ? ({cand_link, cand_speed, cand_duplex} != {link_q, speed_q, duplex_q})
                                     : link_q);

  always_ff @(posedge gmii_rx_clk or posedge reset) begin
    if (reset) state <= MONITOR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_apply  = 1'b0;
    unique case (state)
      MONITOR: if (change_pending) state_nxt = PENDING;
      PENDING: begin
        if (!accepted)    state_nxt = MONITOR;
        else if (tx_idle) state_nxt = APPLY;
      end
      APPLY: begin
        // A sample landing on the PENDING->APPLY edge can still knock the candidate out.
        do_apply  = accepted;
        state_nxt = MONITOR;
      end
      default: state_nxt = MONITOR;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or posedge reset) begin
    if (reset) begin
      speed_q  <= DEFAULT_SPEED;
      duplex_q <= DEFAULT_DUPLEX;
      link_q   <= 1'b0;
      hold_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      hold_q <= (state_nxt != MONITOR);
      upd_q  <= do_apply;
      if (do_apply) begin
        link_q <= cand_link;
        if (cand_link) begin
          speed_q  <= cand_speed;
          duplex_q <= cand_duplex;
        end
      end
    end
  end

  assign bus.speed_selection = speed_q;
  assign bus.duplex_mode     = duplex_q;
  assign bus.link_up         = link_q;
  assign bus.tx_hold         = hold_q;
  assign bus.cfg_update      = upd_q;

endmodule
